// File: rtl/image_pkg.sv
// Shared types and BMP header helper for the image_write frame sink.
// The header function is shared with the verification environment.
package image_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    localparam int BMP_HDR_BYTES = 54;

    // Every header field after 'BM' is a 32-bit little-endian word at 2+4k;
    // bytes 26..29 hold the two 16-bit fields planes=1 and bpp=24 as one word.
    function automatic logic [7:0] bmp_hdr_byte(input int idx,
                                                input int width,
                                                input int height);
        int          npay;
        int          k;
        int          off;
        logic [31:0] fld;
        logic [31:0] sh;
        npay = width * height * 3;
        if (idx == 0) return 8'h42;
        if (idx == 1) return 8'h4D;
        k   = (idx - 2) / 4;
        off = (idx - 2) % 4;
        case (k)
            0:       fld = 32'(BMP_HDR_BYTES + npay);
            2:       fld = 32'(BMP_HDR_BYTES);
            3:       fld = 32'd40;
            4:       fld = 32'(width);
            5:       fld = 32'(height);
            6:       fld = 32'h0018_0001;
            8:       fld = 32'(npay);
            default: fld = '0;
        endcase
        sh = fld >> (8 * off);
        return sh[7:0];
    endfunction

endpackage

// File: rtl/image_write_if.sv
// Pixel-pair input stream and byte output stream of image_write.
// slave is the sink side, master is the source/consumer side.
interface image_write_if;

    logic       VSYNC;
    logic       HSYNC;
    logic [7:0] DATA_R0;
    logic [7:0] DATA_G0;
    logic [7:0] DATA_B0;
    logic [7:0] DATA_R1;
    logic [7:0] DATA_G1;
    logic [7:0] DATA_B1;
    logic       OUT_VALID;
    logic [7:0] OUT_DATA;
    logic       OUT_LAST;
    logic       OUT_READY;
    logic       write_done;
    logic       drop_err;

    modport slave (
        input  VSYNC, HSYNC,
        input  DATA_R0, DATA_G0, DATA_B0,
        input  DATA_R1, DATA_G1, DATA_B1,
        input  OUT_READY,
        output OUT_VALID, OUT_DATA, OUT_LAST,
        output write_done, drop_err
    );

    modport master (
        output VSYNC, HSYNC,
        output DATA_R0, DATA_G0, DATA_B0,
        output DATA_R1, DATA_G1, DATA_B1,
        output OUT_READY,
        input  OUT_VALID, OUT_DATA, OUT_LAST,
        input  write_done, drop_err
    );

endinterface

// File: rtl/image_write_addr.sv
// Row/column/pair counters and bottom-up buffer base address
// for the pixel pair currently presented to image_write.
module image_write_addr
    import image_pkg::*;
#(
    parameter  int WIDTH  = 768,
    parameter  int HEIGHT = 512,
    localparam int AW     = $clog2(WIDTH * HEIGHT * 3)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [AW-1:0] base_o,
    output logic          done_o
);

    localparam int NPAIR = WIDTH * HEIGHT / 2;
    localparam int RW    = $clog2(HEIGHT + 1);
    localparam int CW    = $clog2(WIDTH);
    localparam int PW    = $clog2(NPAIR + 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] pair_q, pair_d;

    // Next counter values: restart wins over an accepted pair.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        pair_d = pair_q;
        if (clr_i) begin
            row_d  = '0;
            col_d  = '0;
            pair_d = '0;
        end else if (adv_i) begin
            pair_d = pair_q + PW'(1);
            if (col_q == CW'(WIDTH - 2)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(2);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            row_q  <= '0;
            col_q  <= '0;
            pair_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            pair_q <= pair_d;
        end
    end

    assign base_o = AW'(WIDTH * 3 * (HEIGHT - 1 - int'(row_q))
                        + 3 * int'(col_q));
    assign done_o = adv_i && !clr_i && (pair_q == PW'(NPAIR - 1));

endmodule

// File: rtl/image_write.sv
// Frame sink: captures a two-pixel-per-cycle RGB frame into a bottom-up
// byte buffer, then streams a BMP header plus payload as valid/ready bytes.
module image_write
    import image_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input logic          HCLK,
    input logic          HRESETn,
    image_write_if.slave bus
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int NPAY = NPIX * 3;
    localparam int NTOT = BMP_HDR_BYTES + NPAY;
    localparam int AW   = $clog2(NPAY);
    localparam int IW   = $clog2(NTOT);

    state_t        state_q;
    logic [IW-1:0] byte_idx_q;
    logic          drop_err_q;
    logic [7:0]    buf_q [NPAY];

    logic          clr;
    logic          adv;
    logic          done;
    logic          fire;
    logic          out_valid;
    logic [AW-1:0] base;
    logic [AW-1:0] pay_addr;
    logic [7:0]    rd_byte;

    assign clr = bus.VSYNC && (state_q == ST_IDLE ||
                               state_q == ST_CAPTURE ||
                               state_q == ST_DONE);
    assign adv = (state_q == ST_CAPTURE) && bus.HSYNC && !bus.VSYNC;

    image_write_addr #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_addr (
        .clk_i (HCLK),
        .rst_ni(HRESETn),
        .clr_i (clr),
        .adv_i (adv),
        .base_o(base),
        .done_o(done)
    );

    // Pixel buffer write: one accepted pair fills six consecutive bytes.
    always_ff @(posedge HCLK) begin
        if (adv) begin
            buf_q[base]           <= bus.DATA_R0;
            buf_q[base + AW'(1)]  <= bus.DATA_G0;
            buf_q[base + AW'(2)]  <= bus.DATA_B0;
            buf_q[base + AW'(3)]  <= bus.DATA_R1;
            buf_q[base + AW'(4)]  <= bus.DATA_G1;
            buf_q[base + AW'(5)]  <= bus.DATA_B1;
        end
    end

    assign out_valid = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
    assign fire      = out_valid && bus.OUT_READY;
    assign pay_addr  = AW'(byte_idx_q - IW'(BMP_HDR_BYTES));

    // Output byte is a pure function of byte_idx, so it holds during stalls.
    always_comb begin
        rd_byte = 8'h00;
        if (state_q == ST_HEADER)
            rd_byte = bmp_hdr_byte(int'(byte_idx_q), WIDTH, HEIGHT);
        else if (state_q == ST_PAYLOAD)
            rd_byte = buf_q[pay_addr];
    end

    // Frame FSM, byte index and sticky stray-HSYNC flag.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            drop_err_q <= 1'b0;
        end else begin
            if (bus.HSYNC && state_q != ST_CAPTURE)
                drop_err_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (bus.VSYNC) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (done) begin
                        state_q    <= ST_HEADER;
                        byte_idx_q <= '0;
                    end
                end
                ST_HEADER: begin
                    if (fire) begin
                        byte_idx_q <= byte_idx_q + IW'(1);
                        if (byte_idx_q == IW'(BMP_HDR_BYTES - 1))
                            state_q <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (fire) begin
                        if (byte_idx_q == IW'(NTOT - 1))
                            state_q <= ST_DONE;
                        else
                            byte_idx_q <= byte_idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.VSYNC) begin
                        state_q    <= ST_CAPTURE;
                        byte_idx_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.OUT_VALID  = out_valid;
    assign bus.OUT_DATA   = rd_byte;
    assign bus.OUT_LAST   = out_valid && (byte_idx_q == IW'(NTOT - 1));
    assign bus.write_done = (state_q == ST_DONE);
    assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_image_write.sv
// Directed bench for image_write on a 4x2 frame (78-byte file).
// Expected file bytes come from a hand-filled table.
module tb_image_write;
    import image_pkg::*;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NTOT = 78;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } vec_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    image_write_if bus();

    image_write #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int         nvec = 0;
    int         nbad = 0;
    logic [7:0] pd  [7][6];
    logic [7:0] exp_f [NTOT];
    logic [7:0] got [$];
    int         nlast;
    int         last_pos;
    vec_t       hv [10];
    int         bases [4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic drive_data(input int p);
        bus.DATA_R0 = pd[p][0];
        bus.DATA_G0 = pd[p][1];
        bus.DATA_B0 = pd[p][2];
        bus.DATA_R1 = pd[p][3];
        bus.DATA_G1 = pd[p][4];
        bus.DATA_B1 = pd[p][5];
    endtask

    task automatic pair(input int p);
        @(negedge HCLK);
        bus.VSYNC = 1'b0;
        bus.HSYNC = 1'b1;
        drive_data(p);
    endtask

    task automatic vs(input bit hs, input int p);
        @(negedge HCLK);
        bus.VSYNC = 1'b1;
        bus.HSYNC = hs;
        drive_data(p);
    endtask

    task automatic quiet();
        @(negedge HCLK);
        bus.VSYNC = 1'b0;
        bus.HSYNC = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        bus.VSYNC = 1'b0;
        bus.HSYNC = 1'b0;
        bus.OUT_READY = 1'b0;
        drive_data(0);
        repeat (2) @(negedge HCLK);
        chk("rst_valid", 32'(bus.OUT_VALID), 0);
        chk("rst_data", 32'(bus.OUT_DATA), 0);
        chk("rst_last", 32'(bus.OUT_LAST), 0);
        chk("rst_done", 32'(bus.write_done), 0);
        chk("rst_drop", 32'(bus.drop_err), 0);
        HRESETn = 1'b1;
    endtask

    task automatic frame();
        vs(1'b0, 0);
        for (int p = 0; p < 4; p++) pair(p);
    endtask

    // Consume bytes; bp selects the 1,0,0,1 ready pattern, stray injects one
    // HSYNC at that cycle, abort_n asserts reset once that many bytes passed.
    task automatic collect(input bit bp, input int stray, input int abort_n);
        bit         rdy;
        bit         prev_stall;
        bit         prev_last_hs;
        logic [7:0] prev_d;
        int         c;
        got.delete();
        nlast = 0;
        last_pos = -1;
        prev_stall = 0;
        prev_last_hs = 0;
        prev_d = 8'h00;
        c = 0;
        forever begin
            @(negedge HCLK);
            bus.VSYNC = 1'b0;
            bus.HSYNC = (c == stray);
            if (abort_n >= 0 && got.size() == abort_n) begin
                HRESETn = 1'b0;
                bus.OUT_READY = 1'b0;
                return;
            end
            if (bus.write_done) begin
                chk("done_after_last", 32'(prev_last_hs), 1);
                return;
            end
            rdy = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            bus.OUT_READY = rdy;
            if (prev_stall)
                chk($sformatf("stall_hold_%0d", got.size()),
                    {23'd0, bus.OUT_VALID, bus.OUT_DATA}, {23'd0, 1'b1, prev_d});
            prev_last_hs = 0;
            if (bus.OUT_VALID && rdy) begin
                if (bus.OUT_LAST) begin
                    nlast++;
                    last_pos = got.size();
                    prev_last_hs = 1;
                end
                got.push_back(bus.OUT_DATA);
            end
            prev_stall = bus.OUT_VALID && !rdy;
            prev_d = bus.OUT_DATA;
            c++;
            if (c > 2000) begin
                nvec++;
                nbad++;
                $display("FAIL collect_timeout: got %0d bytes want done", got.size());
                return;
            end
        end
    endtask

    task automatic check_file(input string tag);
        chk({tag, "_nbytes"}, got.size(), NTOT);
        chk({tag, "_nlast"}, nlast, 1);
        chk({tag, "_lastpos"}, last_pos, NTOT - 1);
        for (int i = 0; i < NTOT && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_f[i]));
    endtask

    initial begin
        pd[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int p = 1; p < 7; p++)
            for (int k = 0; k < 6; k++)
                pd[p][k] = 8'(8'h91 + p * 16 + k);
        hv = '{'{0, 8'h42}, '{1, 8'h4D}, '{2, 8'h4E}, '{10, 8'h36},
               '{14, 8'h28}, '{18, 8'h04}, '{22, 8'h02}, '{26, 8'h01},
               '{28, 8'h18}, '{34, 8'h18}};
        bases = '{12, 18, 0, 6};
        for (int i = 0; i < NTOT; i++) exp_f[i] = 8'h00;
        foreach (hv[i]) exp_f[hv[i].idx] = hv[i].val;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 6; k++)
                exp_f[54 + bases[p] + k] = pd[p][k];

        // Plain frame with header and payload check.
        do_reset();
        frame();
        collect(1'b0, -1, -1);
        check_file("s1");
        chk("s1_b66", 32'(got.size() > 71 ? got[66] : 8'h00), 32'h11);
        chk("s1_b71", 32'(got.size() > 71 ? got[71] : 8'h00), 32'h66);
        chk("s1_done_hold", 32'(bus.write_done), 1);

        // Backpressure, restarted from DONE.
        vs(1'b0, 0);
        quiet();
        chk("s3_done_clr", 32'(bus.write_done), 0);
        for (int p = 0; p < 4; p++) pair(p);
        collect(1'b1, -1, -1);
        check_file("s3");

        // Restart mid-frame, VSYNC+HSYNC together, then bubbles.
        vs(1'b0, 0);
        pair(4);
        pair(5);
        vs(1'b1, 6);
        pair(0);
        pair(1);
        for (int i = 0; i < 3; i++) begin
            quiet();
            chk("s4_no_hdr", 32'(bus.OUT_VALID), 0);
        end
        pair(2);
        pair(3);
        collect(1'b0, -1, -1);
        check_file("s4");

        // Stray HSYNC in IDLE and during payload.
        do_reset();
        @(negedge HCLK);
        bus.HSYNC = 1'b1;
        quiet();
        chk("s5_drop_set", 32'(bus.drop_err), 1);
        frame();
        collect(1'b0, 60, -1);
        check_file("s5");
        chk("s5_drop_kept", 32'(bus.drop_err), 1);

        // Reset while streaming byte 60.
        do_reset();
        frame();
        collect(1'b0, -1, 60);
        @(negedge HCLK);
        chk("s6_valid", 32'(bus.OUT_VALID), 0);
        chk("s6_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("s6_drop", 32'(bus.drop_err), 0);
        HRESETn = 1'b1;
        frame();
        collect(1'b0, -1, -1);
        check_file("s6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
